// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV base ops, iterative RV-M multiply/divide (1 bit/cycle).
// Define FAST_MUL_EN to replace the iterative multiplier with a combinational one.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_alu_dec,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7,
    input  logic            i_mext,
    input  logic            i_opcode5,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_valid
);
    localparam int SHAMT_W = $clog2(XLEN);

`ifdef FAST_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic [XLEN-1:0]      lo_q, lo_d;
    logic [XLEN-1:0]      opnd_q, opnd_d;
    logic [XLEN-1:0]      opa_q, opa_d;
    logic [2:0]           f3_q, f3_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 divz_q, divz_d;
    logic                 base_vld_q, base_vld_d;
    logic [XLEN-1:0]      base_res_q, base_res_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 valid_q, valid_d;

    logic                 is_m, m_iter;
    logic                 a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]      mag_a, mag_b;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      sra_res;
    logic                 slt_bit, sltu_bit;
    logic [XLEN-1:0]      alu_res;
    logic [XLEN:0]        div_shift, div_diff;
    logic                 qbit;
    logic [2*XLEN-1:0]    prod, prod_fix;
    logic [XLEN-1:0]      done_res;

    // Operand signedness: MUL/MULH/MULHSU sign a, MUL/MULH sign b, DIV/REM sign both.
    always_comb begin
        is_m  = (i_alu_dec == 2'b01) && i_mext && i_opcode5;
        a_sgn = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
        b_sgn = i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1];
        sa    = a_sgn & i_op_a[XLEN-1];
        sb    = b_sgn & i_op_b[XLEN-1];
        mag_a = sa ? -i_op_a : i_op_a;
        mag_b = sb ? -i_op_b : i_op_b;
`ifdef FAST_MUL_EN
        m_iter = is_m && i_funct3[2];
`else
        m_iter = is_m;
`endif
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN+1:0] fm_a, fm_b, fm_p;
    logic [XLEN-1:0]   fm_res;
    always_comb begin
        fm_a   = {{(XLEN+2){sa}}, i_op_a};
        fm_b   = {{(XLEN+2){sb}}, i_op_b};
        fm_p   = fm_a * fm_b;
        fm_res = (i_funct3[1:0] == 2'b00) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        shamt    = i_op_b[SHAMT_W-1:0];
        sra_res  = $signed(i_op_a) >>> shamt;
        slt_bit  = $signed(i_op_a) < $signed(i_op_b);
        sltu_bit = i_op_a < i_op_b;
        alu_res  = i_op_a + i_op_b;
        if (i_alu_dec == 2'b10) begin
            alu_res = i_op_b;
        end else if (i_alu_dec == 2'b01) begin
            case (i_funct3)
                3'b000: if (i_funct7 && i_opcode5) alu_res = i_op_a - i_op_b;
                3'b001: alu_res = i_op_a << shamt;
                3'b010: alu_res = {{(XLEN-1){1'b0}}, slt_bit};
                3'b011: alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
                3'b100: alu_res = i_op_a ^ i_op_b;
                3'b101: alu_res = i_funct7 ? sra_res : (i_op_a >> shamt);
                3'b110: alu_res = i_op_a | i_op_b;
                default: alu_res = i_op_a & i_op_b;
            endcase
`ifdef FAST_MUL_EN
            if (is_m && !i_funct3[2]) alu_res = fm_res;
`endif
        end
    end

    // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
    always_comb begin
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        qbit      = ~div_diff[XLEN];
    end

    // Sign fix-up at DONE; divide-by-zero bypasses it so REM returns a unchanged.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = negq_q ? -prod : prod;
        if (f3_q[2]) begin
            if (divz_q)
                done_res = f3_q[1] ? opa_q : '1;
            else if (f3_q[1])
                done_res = negr_q ? -hi_q : hi_q;
            else
                done_res = negq_q ? -lo_q : lo_q;
        end else begin
            done_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

`ifndef FAST_MUL_EN
    logic [XLEN:0] mul_sum;
    always_comb mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opnd_d     = opnd_q;
        opa_d      = opa_q;
        f3_d       = f3_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        divz_d     = divz_q;
        base_vld_d = 1'b0;
        base_res_d = base_res_q;
        result_d   = result_q;
        valid_d    = 1'b0;

        if (base_vld_q) begin
            result_d = base_res_q;
            valid_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (m_iter) begin
                        cnt_d  = '0;
                        hi_d   = '0;
                        lo_d   = i_funct3[2] ? mag_a : mag_b;
                        opnd_d = i_funct3[2] ? mag_b : mag_a;
                        opa_d  = i_op_a;
                        f3_d   = i_funct3;
                        negq_d = sa ^ sb;
                        negr_d = sa;
                        divz_d = (i_op_b == '0);
`ifdef FAST_MUL_EN
                        state_d = S_DIV;
`else
                        state_d = i_funct3[2] ? S_DIV : S_MUL;
`endif
                    end else begin
                        base_vld_d = 1'b1;
                        base_res_d = alu_res;
                    end
                end
            end
`ifndef FAST_MUL_EN
            S_MUL: begin
                hi_d  = mul_sum[XLEN:1];
                lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHAMT_W'(XLEN-1)) state_d = S_DONE;
            end
`endif
            S_DIV: begin
                hi_d  = qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHAMT_W'(XLEN-1)) state_d = S_DONE;
            end
            S_DONE: begin
                result_d = done_res;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            opa_q      <= '0;
            f3_q       <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            divz_q     <= 1'b0;
            base_vld_q <= 1'b0;
            base_res_q <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opnd_q     <= opnd_d;
            opa_q      <= opa_d;
            f3_q       <= f3_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            divz_q     <= divz_d;
            base_vld_q <= base_vld_d;
            base_res_q <= base_res_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_result = result_q;
    assign o_valid  = valid_q;

endmodule
